// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
//   Shared types for the RSA exponentiation control path.
//   op_t        : operand selection presented to the Montgomery datapath
//                 (SQR: A=acc,B=acc; MUL: A=acc,B=base; CVT: A=acc,B=1).
//   exp_state_t : externally visible sequencing state. The parent owns
//                 IDLE/FIN; the product sequencer owns CLR..HOLD.
//   cnt_w()     : width of the bit/iteration counters, never below 1 bit.
// ---------------------------------------------------------------------------
package rsa_pkg;

    typedef enum logic [1:0] {
        OP_SQR = 2'b00,
        OP_MUL = 2'b01,
        OP_CVT = 2'b10
    } op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LOAD = 3'd2,
        ITER = 3'd3,
        CAPT = 3'd4,
        HOLD = 3'd5,
        FIN  = 3'd6
    } exp_state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mmm_seq.sv
// ---------------------------------------------------------------------------
// mmm_seq
//   Single Montgomery-product sequencer: CLR -> LOAD -> ITER x WIDTH ->
//   CAPT -> HOLD, then either straight into the next product (go=1 while in
//   HOLD) or back to IDLE.
//
//   Handshake with the parent:
//     go  (in)  : sampled in IDLE and in HOLD; 1 starts (or chains) a product.
//     fin (out) : high for the HOLD cycle; the parent decides the next
//                 operation in that same cycle and answers with go.
//   Both sides only advance on cycles with ena=1, so a stalled HOLD keeps
//   fin high and the decision is simply re-evaluated, never duplicated.
//
// Ports
//   clk, rstb       clock, asynchronous active-low reset
//   ena             global enable, all state holds when 0
//   go              product request from the parent
//   clear/ld_a/ld_r multiplier strobes (CLR / LOAD / CAPT)
//   lock            result hold: set on entering HOLD, cleared on next CLR
//   acc_we          accumulator write strobe (HOLD)
//   fin             product complete (HOLD)
//   seq_state       current sequencer state, for debug and status
// ---------------------------------------------------------------------------
module mmm_seq
    import rsa_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       ena,
    input  logic       go,
    output logic       clear,
    output logic       ld_a,
    output logic       ld_r,
    output logic       lock,
    output logic       acc_we,
    output logic       fin,
    output exp_state_t seq_state
);

    localparam int            CW        = cnt_w(WIDTH);
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

    exp_state_t    seq_q, seq_d;
    logic [CW-1:0] iter_cnt_q, iter_cnt_d;
    logic          lock_q, lock_d;

    always_comb begin
        seq_d      = seq_q;
        iter_cnt_d = iter_cnt_q;
        lock_d     = lock_q;
        if (ena) begin
            case (seq_q)
                IDLE: if (go) seq_d = CLR;
                CLR:  seq_d = LOAD;
                LOAD: begin
                    seq_d      = ITER;
                    iter_cnt_d = '0;
                end
                ITER: begin
                    if (iter_cnt_q == ITER_LAST) begin
                        seq_d      = CAPT;
                        iter_cnt_d = '0;
                    end else begin
                        iter_cnt_d = iter_cnt_q + 1'b1;
                    end
                end
                CAPT: seq_d = HOLD;
                HOLD: seq_d = go ? CLR : IDLE;
                default: seq_d = IDLE;
            endcase
            // lock is the only strobe that outlives its state: it keeps the
            // final result stable after the run until a new product clears it.
            if (seq_d == HOLD) begin
                lock_d = 1'b1;
            end else if (seq_d == CLR) begin
                lock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            seq_q      <= IDLE;
            iter_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            iter_cnt_q <= iter_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign clear     = (seq_q == CLR);
    assign ld_a      = (seq_q == LOAD);
    assign ld_r      = (seq_q == CAPT);
    assign acc_we    = (seq_q == HOLD);
    assign fin       = (seq_q == HOLD);
    assign lock      = lock_q;
    assign seq_state = seq_q;

endmodule

// File: rtl/mmp_exp_ctrl.sv
// ---------------------------------------------------------------------------
// mmp_exp_ctrl
//   Constant-time square-and-multiply sequencer for the bit-serial
//   Montgomery multiplier. The exponent is scanned MSB first; every bit is
//   squared, a multiply follows only for a 1 bit, and the run ends with one
//   convert-out product (B=1). Each product takes WIDTH+4 cycles; a run
//   takes WIDTH + popcount(E) + 1 products, and done appears
//   1 + ops*(WIDTH+4) cycles after the cycle in which start was accepted.
//
// Ports
//   clk, rstb    clock, asynchronous active-low reset
//   ena          global enable; all state and outputs hold when 0
//   start        run request, sampled only in IDLE
//   E            exponent, captured when start is accepted
//   busy         high from accepted start through the done cycle
//   done         one-cycle pulse, final result valid on the multiplier R
//   clear, ld_a, ld_r, lock, acc_we   multiplier / accumulator strobes
//   op           operand select for the current product (stable per product)
//   dbg_state    combined sequencing state (exp_state_t encoding)
// ---------------------------------------------------------------------------
module mmp_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] E,
    output logic             busy,
    output logic             done,
    output logic             clear,
    output logic             ld_a,
    output logic             ld_r,
    output logic             lock,
    output logic [1:0]       op,
    output logic             acc_we,
    output logic [2:0]       dbg_state
);

    localparam int            CW      = cnt_w(WIDTH);
    localparam logic [CW-1:0] BIT_TOP = CW'(WIDTH - 1);

    // Coarse run phase; the product-level detail lives in mmm_seq.
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_RUN  = 2'd1;
    localparam logic [1:0] PH_FIN  = 2'd2;

    logic [1:0]       ph_q, ph_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [CW-1:0]    bit_idx_q, bit_idx_d;
    op_t              op_q, op_d;

    logic       go;
    logic       advance;
    logic       seq_fin;
    exp_state_t seq_state;

    mmm_seq #(
        .WIDTH(WIDTH)
    ) u_seq (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .go        (go),
        .clear     (clear),
        .ld_a      (ld_a),
        .ld_r      (ld_r),
        .lock      (lock),
        .acc_we    (acc_we),
        .fin       (seq_fin),
        .seq_state (seq_state)
    );

    always_comb begin
        ph_d      = ph_q;
        e_d       = e_q;
        bit_idx_d = bit_idx_q;
        op_d      = op_q;
        go        = 1'b0;
        advance   = 1'b0;
        if (ena) begin
            case (ph_q)
                PH_IDLE: begin
                    if (start) begin
                        ph_d      = PH_RUN;
                        e_d       = E;
                        bit_idx_d = BIT_TOP;
                        op_d      = OP_SQR;
                        go        = 1'b1;
                    end
                end
                PH_RUN: begin
                    // Decide the following product while the current one is
                    // in HOLD so the next CLR follows without a gap.
                    if (seq_fin) begin
                        case (op_q)
                            OP_SQR: begin
                                if (e_q[bit_idx_q]) begin
                                    op_d = OP_MUL;
                                    go   = 1'b1;
                                end else begin
                                    advance = 1'b1;
                                end
                            end
                            OP_MUL:  advance = 1'b1;
                            default: ph_d = PH_FIN;
                        endcase
                    end
                end
                PH_FIN:  ph_d = PH_IDLE;
                default: ph_d = PH_IDLE;
            endcase
            // Bit finished: move to the next lower bit, or convert out
            // after bit 0. bit_idx therefore never wraps.
            if (advance) begin
                go = 1'b1;
                if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - 1'b1;
                    op_d      = OP_SQR;
                end else begin
                    op_d = OP_CVT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ph_q      <= PH_IDLE;
            e_q       <= '0;
            bit_idx_q <= '0;
            op_q      <= OP_SQR;
        end else begin
            ph_q      <= ph_d;
            e_q       <= e_d;
            bit_idx_q <= bit_idx_d;
            op_q      <= op_d;
        end
    end

    assign busy = (ph_q != PH_IDLE);
    assign done = (ph_q == PH_FIN);
    assign op   = op_q;

    always_comb begin
        dbg_state = seq_state;
        if (ph_q == PH_IDLE) begin
            dbg_state = IDLE;
        end else if (ph_q == PH_FIN) begin
            dbg_state = FIN;
        end
    end

endmodule

// File: tb/tb_mmp_exp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmp_exp_ctrl
//   Self-checking bench. A reference model turns each accepted exponent into
//   the full list of expected per-cycle output vectors (one entry per
//   enabled clock), built from the operation list (square every bit,
//   multiply on ones, convert last). A compare process checks the DUT
//   against the model on every negative edge. Directed runs pin the model
//   with hand-computed latencies and operation lists.
//   Output vector layout: {busy, done, clear, ld_a, ld_r, lock, op[1:0], acc_we}
// ---------------------------------------------------------------------------
module tb_mmp_exp_ctrl;
  import rsa_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         ena = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] E_in = '0;
  logic         busy, done, clear, ld_a, ld_r, lock, acc_we;
  logic [1:0]   op;
  logic [2:0]   dbg_state;

  mmp_exp_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .start     (start),
    .E         (E_in),
    .busy      (busy),
    .done      (done),
    .clear     (clear),
    .ld_a      (ld_a),
    .ld_r      (ld_r),
    .lock      (lock),
    .op        (op),
    .acc_we    (acc_we),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  function automatic logic [8:0] mkv(input bit b, input bit d, input bit c, input bit la,
                                     input bit lr, input bit lk, input logic [1:0] o,
                                     input bit aw);
    return {b, d, c, la, lr, lk, o, aw};
  endfunction

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];
  logic [1:0] exp_ops[$];
  logic [8:0] cur = '0;
  int         t = 0;
  int         accept_t = 0;
  int         model_len = 0;

  // Per-run observations of the DUT.
  logic [1:0] seen_ops[$];
  int         ldr_cnt = 0;
  bit         done_seen = 1'b0;
  int         done_rel = 0;
  int         f_clr = -1, f_lda = -1, f_ldr = -1, f_acc = -1;

  function automatic void build(input logic [W-1:0] e);
    logic [1:0] o;
    exp_q.delete();
    exp_ops.delete();
    for (int i = W - 1; i >= 0; i--) begin
      exp_ops.push_back(2'b00);
      if (e[i]) exp_ops.push_back(2'b01);
    end
    exp_ops.push_back(2'b10);
    foreach (exp_ops[k]) begin
      o = exp_ops[k];
      exp_q.push_back(mkv(1, 0, 1, 0, 0, 0, o, 0));
      exp_q.push_back(mkv(1, 0, 0, 1, 0, 0, o, 0));
      for (int j = 0; j < W; j++) exp_q.push_back(mkv(1, 0, 0, 0, 0, 0, o, 0));
      exp_q.push_back(mkv(1, 0, 0, 0, 1, 0, o, 0));
      exp_q.push_back(mkv(1, 0, 0, 0, 0, 1, o, 1));
    end
    exp_q.push_back(mkv(1, 1, 0, 0, 0, 1, 2'b10, 0));
  endfunction

  // One model step per enabled clock edge; ena=0 freezes the expectation.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      exp_q.delete();
      cur = '0;
    end else begin
      t++;
      if (ena) begin
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
        end else if (start && !cur[8]) begin
          build(E_in);
          model_len = exp_q.size();
          accept_t  = t;
          seen_ops.delete();
          ldr_cnt   = 0;
          done_seen = 1'b0;
          f_clr = -1; f_lda = -1; f_ldr = -1; f_acc = -1;
          cur = exp_q.pop_front();
        end else begin
          // Idle: strobes drop, lock and op keep their last value.
          cur = cur & 9'h00E;
        end
      end
    end
  end

  // ---------------- scoreboard compare + monitor ----------------
  always @(negedge clk) begin
    logic [8:0] v;
    int rel;
    v   = {busy, done, clear, ld_a, ld_r, lock, op, acc_we};
    rel = t - accept_t + 1;
    chk("outputs_vs_model", {23'd0, v}, {23'd0, cur});
    if (ena && rstb) begin
      if (acc_we) seen_ops.push_back(op);
      if (ld_r)   ldr_cnt++;
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_rel  = rel;
    end
    if (clear  && f_clr < 0) f_clr = rel;
    if (ld_a   && f_lda < 0) f_lda = rel;
    if (ld_r   && f_ldr < 0) f_ldr = rel;
    if (acc_we && f_acc < 0) f_acc = rel;
  end

  function automatic logic [31:0] pack_seen();
    logic [31:0] p = '0;
    foreach (seen_ops[k]) p = (p << 2) | {30'd0, seen_ops[k]};
    return p;
  endfunction

  function automatic logic [31:0] pack_model();
    logic [31:0] p = '0;
    foreach (exp_ops[k]) p = (p << 2) | {30'd0, exp_ops[k]};
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [W-1:0] e);
    ena   = 1'b1;
    E_in  = e;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int stall_pct, input bit chatter);
    int n = 0;
    while (!done_seen && n < 3000) begin
      if (stall_pct > 0) ena = ($urandom_range(0, 99) >= stall_pct);
      if (chatter) begin
        start = 1'($urandom_range(0, 1));
        E_in  = W'($urandom);
      end
      tick();
      n++;
    end
    chk("done_reached", {31'd0, done_seen}, 32'd1);
    ena   = 1'b1;
    start = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ops;
    int n;
    logic [W-1:0] e;

    // 1: reset held with start high -> everything quiet.
    rstb  = 1'b0;
    start = 1'b1;
    E_in  = W'($urandom);
    repeat (3) begin
      tick();
      chk("reset_outputs", {23'd0, busy, done, clear, ld_a, ld_r, lock, op, acc_we}, 32'd0);
    end
    start = 1'b0;
    rstb  = 1'b1;
    repeat (4) tick();
    chk("idle_after_reset", {30'd0, busy, clear}, 32'd0);

    // 2: E=1011 -> S,M,S,S,M,S,M,C, done at cycle 65.
    launch(4'b1011);
    chk("e1011_model_len", model_len, 32'd65);
    wait_done(0, 1'b0);
    chk("e1011_done_cycle", done_rel, 32'd65);
    chk("e1011_first_acc_we", f_acc, 32'd8);
    chk("e1011_op_count", seen_ops.size(), 32'd8);
    chk("e1011_op_list", pack_seen(), 32'h1046);
    chk("e1011_ld_r_count", ldr_cnt, 32'd8);

    // 3: E=0 -> S,S,S,S,C, done at cycle 41; strobe order in first product.
    launch(4'b0000);
    chk("e0_model_len", model_len, 32'd41);
    wait_done(0, 1'b0);
    chk("e0_done_cycle", done_rel, 32'd41);
    chk("e0_op_count", seen_ops.size(), 32'd5);
    chk("e0_op_list", pack_seen(), 32'h0002);
    chk("e0_first_clear", f_clr, 32'd1);
    chk("e0_first_ld_a", f_lda, 32'd2);
    chk("e0_first_ld_r", f_ldr, 32'd7);
    chk("e0_first_acc_we", f_acc, 32'd8);

    // 4: 3-cycle stalls in ITER and in CAPT -> done exactly 6 cycles later.
    e   = 4'b0110;
    ops = W + $countones(e) + 1;
    launch(e);
    repeat (3) tick();
    ena = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    n = 0;
    while (!ld_r && n < 50) begin
      tick();
      n++;
    end
    chk("capt_reached", {31'd0, ld_r}, 32'd1);
    ena = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    wait_done(0, 1'b0);
    chk("stall_done_cycle", done_rel, 1 + ops * (W + 4) + 6);
    chk("stall_ld_r_once", ldr_cnt, ops);
    chk("stall_op_list", pack_seen(), pack_model());

    // 5: start and E chatter during the run are ignored.
    launch(4'b1001);
    wait_done(0, 1'b1);
    chk("chatter_done_cycle", done_rel, 32'd57);
    chk("chatter_op_count", seen_ops.size(), 32'd7);
    chk("chatter_op_list", pack_seen(), 32'h0406);

    // Random exponents with random enable stalls.
    for (int r = 0; r < 6; r++) begin
      e   = W'($urandom);
      ops = W + $countones(e) + 1;
      launch(e);
      wait_done(25, 1'b0);
      chk("rand_op_count", seen_ops.size(), ops);
      chk("rand_op_list", pack_seen(), pack_model());
      chk("rand_ld_r_count", ldr_cnt, ops);
    end

    // 6: reset in the middle of a multiply, then a clean full run.
    launch(4'b1111);
    n = 0;
    while (!(busy && op == 2'b01 && !clear && !ld_a) && n < 100) begin
      tick();
      n++;
    end
    chk("mul_reached", {31'd0, (op == 2'b01)}, 32'd1);
    rstb = 1'b0;
    #1;
    chk("async_reset_outputs", {23'd0, busy, done, clear, ld_a, ld_r, lock, op, acc_we}, 32'd0);
    repeat (2) tick();
    rstb = 1'b1;
    tick();
    e   = W'($urandom);
    ops = W + $countones(e) + 1;
    launch(e);
    wait_done(0, 1'b0);
    chk("post_reset_done_cycle", done_rel, 1 + ops * (W + 4));
    chk("post_reset_first_op_sqr", {30'd0, seen_ops[0]}, 32'd0);
    chk("post_reset_op_list", pack_seen(), pack_model());

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
